// File: rtl/merge2_pkg.sv
// Shared types and constants for the two-input round-robin stream merger.
package merge2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } merge_state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way arbiter: a lock pins the grant to one input,
// otherwise the pointer breaks ties between simultaneous requests.
module rr_arb2
  import merge2_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       lock_en,
  input  logic       lock_id,
  output logic       grant_valid,
  output logic       grant_id
);

  // NOTE: every output gets a default first so no path through the block leaves
  // a value unassigned; a missed branch here would otherwise infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = SRC0;
    if (lock_en) begin
      grant_valid = req[lock_id];
      grant_id    = lock_id;
    end else if (req == 2'b11) begin
      grant_valid = 1'b1;
      grant_id    = ptr;
    end else if (req[0]) begin
      grant_valid = 1'b1;
      grant_id    = SRC0;
    end else if (req[1]) begin
      grant_valid = 1'b1;
      grant_id    = SRC1;
    end
  end

endmodule

// File: rtl/merge2_rr.sv
// Two-input round-robin packet merger with a registered output stage.
// A packet owns the output from its first beat until its last beat.
module merge2_rr
  import merge2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src
);

  merge_state_t     state, state_next;
  logic             ptr, ptr_next;
  logic             load, accept;
  logic             grant_valid, grant_id;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;

  assign load = !out_valid || out_ready;

  rr_arb2 u_arb (
    .req         ({in1_valid, in0_valid}),
    .ptr         (ptr),
    .lock_en     (state != IDLE),
    .lock_id     (state == LOCK1),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Readies are held low during reset so no beat is consumed and then lost.
  assign accept    = !rst && load && grant_valid;
  assign in0_ready = accept && (grant_id == SRC0);
  assign in1_ready = accept && (grant_id == SRC1);
  assign sel_data  = (grant_id == SRC1) ? in1_data : in0_data;
  assign sel_last  = (grant_id == SRC1) ? in1_last : in0_last;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (accept) begin
      if (sel_last) begin
        state_next = IDLE;
        ptr_next   = ~grant_id;
      end else begin
        state_next = (grant_id == SRC1) ? LOCK1 : LOCK0;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= SRC0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Payload fields hold across empty cycles; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= SRC0;
    end else if (load) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= sel_data;
        out_last <= sel_last;
        out_src  <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_merge2_rr.sv
// Self-checking bench for merge2_rr: directed scenarios plus randomized
// traffic, compared cycle by cycle against a transaction-level model.
module tb_merge2_rr;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   valid = '0;
  logic [1:0]   last  = '0;
  logic [W-1:0] data [2];
  logic [1:0]   ready;
  logic         out_valid, out_ready, out_last, out_src;
  logic [W-1:0] out_data;

  merge2_rr #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (valid[0]),
    .in0_ready (ready[0]),
    .in0_data  (data[0]),
    .in0_last  (last[0]),
    .in1_valid (valid[1]),
    .in1_ready (ready[1]),
    .in1_data  (data[1]),
    .in1_last  (last[1]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  // Reference model: packet owner (-1 when free), preferred input, output register.
  int           owner;
  bit           mptr;
  bit           mv, ml, ms;
  logic [W-1:0] md;

  beat_t        q [2][$];
  logic [8:0]   hs_log [$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_grant();
    if (mv && !out_ready) return -1;
    if (owner >= 0) return valid[owner] ? owner : -1;
    if (valid == 2'b11) return int'(mptr);
    if (valid[0]) return 0;
    if (valid[1]) return 1;
    return -1;
  endfunction

  // One clock: check readies before the edge, advance the model, check outputs after.
  task automatic cycle(input string tag, output int g);
    logic [1:0] exp_rdy;
    #1;
    g = exp_grant();
    exp_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    check({tag, "/ready"}, ready, exp_rdy);
    if (out_valid && out_ready) hs_log.push_back({out_src, out_data});
    @(posedge clk);
    if (g >= 0) begin
      mv = 1'b1;
      md = data[g];
      ml = last[g];
      ms = g[0];
      if (last[g]) begin
        owner = -1;
        mptr  = ~g[0];
      end else begin
        owner = g;
      end
    end else if (!mv || out_ready) begin
      mv = 1'b0;
    end
    #1;
    check({tag, "/out"}, {out_valid, out_last, out_src, out_data}, {mv, ml, ms, md});
  endtask

  // Producers hold a presented beat until it is taken, then maybe present the next.
  task automatic drive(input int g, input int pct);
    for (int x = 0; x < 2; x++) begin
      if (g == x) void'(q[x].pop_front());
      if (valid[x] && g != x && q[x].size() > 0) begin
        valid[x] = 1'b1;
      end else if (q[x].size() > 0 && $urandom_range(99) < pct) begin
        valid[x] = 1'b1;
        data[x]  = q[x][0].d;
        last[x]  = q[x][0].l;
      end else begin
        valid[x] = 1'b0;
      end
    end
  endtask

  task automatic run_until_drained(input string tag, input int pct, input int rdy_pct, input int budget);
    int  g;
    bit  done;
    done = 1'b0;
    drive(-1, pct);
    for (int n = 0; n < budget; n++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && valid == 2'b00 && !mv) begin
        done = 1'b1;
        break;
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      cycle(tag, g);
      drive(g, pct);
    end
    if (!done) check({tag, "/timeout"}, 0, 1);
  endtask

  // Reset is asserted a few ns after an edge, i.e. asynchronously to the clock.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "/rst_out"}, {out_valid, out_last, out_src, out_data}, 0);
    check({tag, "/rst_ready"}, ready, 2'b00);
    owner = -1;
    mptr  = 1'b0;
    mv    = 1'b0;
    ml    = 1'b0;
    ms    = 1'b0;
    md    = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [8:0] exp [$]);
    check({tag, "/count"}, hs_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < hs_log.size(); i++)
      check($sformatf("%s/beat%0d", tag, i), hs_log[i], exp[i]);
  endtask

  initial begin
    int           g;
    logic [8:0]   exp [$];
    int           nbeats;

    data[0]   = 8'h5A;
    data[1]   = 8'hA5;
    out_ready = 1'b1;
    valid     = 2'b11;
    last      = 2'b11;
    #2;
    do_reset("init");
    valid = 2'b00;

    // Alternation of single-beat packets; input 0 must win the first tie.
    q[0].push_back('{8'hA0, 1'b1});
    q[0].push_back('{8'hA1, 1'b1});
    q[1].push_back('{8'hB0, 1'b1});
    q[1].push_back('{8'hB1, 1'b1});
    hs_log.delete();
    run_until_drained("alt", 100, 100, 50);
    exp = '{{1'b0, 8'hA0}, {1'b1, 8'hB0}, {1'b0, 8'hA1}, {1'b1, 8'hB1}};
    check_log("alt", exp);

    // Packet lock: input 1 waits out the whole 3-beat packet from input 0.
    q[0].push_back('{8'h10, 1'b0});
    q[0].push_back('{8'h11, 1'b0});
    q[0].push_back('{8'h12, 1'b1});
    q[1].push_back('{8'h55, 1'b1});
    hs_log.delete();
    run_until_drained("lock", 100, 100, 50);
    exp = '{{1'b0, 8'h10}, {1'b0, 8'h11}, {1'b0, 8'h12}, {1'b1, 8'h55}};
    check_log("lock", exp);
    check("idle/valid", out_valid, 1'b0);
    check("idle/data", out_data, 8'h55);

    // Backpressure: 0x3C held four cycles, both inputs stalled meanwhile.
    hs_log.delete();
    q[0].push_back('{8'h3C, 1'b1});
    drive(-1, 100);
    out_ready = 1'b1;
    cycle("bp_load", g);
    q[0].push_back('{8'h77, 1'b1});
    q[1].push_back('{8'h88, 1'b1});
    drive(g, 100);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("bp_hold", g);
      check("bp/data", out_data, 8'h3C);
      drive(g, 100);
    end
    run_until_drained("bp", 100, 100, 50);
    exp = '{{1'b0, 8'h3C}, {1'b1, 8'h88}, {1'b0, 8'h77}};
    check_log("bp", exp);

    // Reset mid-packet while input 1 owns the output.
    q[1].push_back('{8'h21, 1'b0});
    q[1].push_back('{8'h22, 1'b1});
    drive(-1, 100);
    out_ready = 1'b1;
    cycle("mid_first", g);
    check("mid/owner_src", out_src, 1'b1);
    q[0].push_back('{8'h31, 1'b1});
    drive(g, 100);
    do_reset("mid");
    hs_log.delete();
    run_until_drained("mid", 100, 100, 50);
    exp = '{{1'b0, 8'h31}, {1'b1, 8'h22}};
    check_log("mid", exp);

    // Randomized multi-beat traffic with random gaps and backpressure.
    hs_log.delete();
    for (int x = 0; x < 2; x++) begin
      for (int p = 0; p < 30; p++) begin
        nbeats = $urandom_range(1, 4);
        for (int b = 0; b < nbeats; b++)
          q[x].push_back('{W'($urandom), (b == nbeats - 1)});
      end
    end
    run_until_drained("rand", 70, 70, 3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
